// File: rtl/fetch_seq_pkg.sv
// Shared constants and types for the fetch sequencer and its decoder neighbours.
package fetch_seq_pkg;

  localparam int unsigned DefPcW = 12;
  localparam int unsigned DefCntW = 16;
  localparam logic [DefPcW-1:0] DefResetPc = 12'h000;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalt
  } state_e;

  // Opcodes the decoder matches to raise halt_req / feed the branch-target calculator.
  localparam logic [3:0] OpBr = 4'hC;
  localparam logic [3:0] OpHlt = 4'hF;

endpackage

// File: rtl/fetch_seq_stage_shift.sv
// One pipeline stage shadow: PC plus valid bit with load, hold and clear.
module fetch_seq_stage_shift #(
  parameter int unsigned W = 12
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         clr_i,
  input  logic [W-1:0] pc_i,
  input  logic         valid_i,
  output logic [W-1:0] pc_o,
  output logic         valid_o
);

  logic [W-1:0] pc_d, pc_q;
  logic         valid_d, valid_q;

  // Clear kills the instruction but keeps the PC; otherwise load or hold.
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      pc_d    = pc_i;
      valid_d = valid_i;
    end
  end

  // Stage register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_seq.sv
// Program-counter sequencer: owns the PC, the IF/ID/EX shadows and the run/halt FSM.
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter int unsigned      PC_W     = DefPcW,
  parameter logic [PC_W-1:0]  RESET_PC = DefResetPc,
  parameter int unsigned      CNT_W    = DefCntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             jflag,
  input  logic [PC_W-1:0]  jdest,
  output logic [PC_W-1:0]  imem_addr,
  output logic             fetch_en,
  output logic             if_valid,
  output logic             id_valid,
  output logic             ex_valid,
  output logic [PC_W-1:0]  ex_pc,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] retire_cnt
);

  state_e           state_d, state_q;
  logic [PC_W-1:0]  pc_d, pc_q;
  logic [CNT_W-1:0] retire_cnt_d, retire_cnt_q;
  logic [PC_W-1:0]  if_pc, id_pc;
  logic             if_load, if_clr, id_load, id_clr, ex_load, ex_clr;
  logic             redirect, hlt;

  // Branch/halt requests only count when EX holds a live instruction.
  assign redirect = jflag & ex_valid & ~halt_req;
  assign hlt      = halt_req & ex_valid;

  // Next state, pc mux and stage controls; priority hlt > redirect > stall.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    flush    = 1'b0;
    fetch_en = 1'b0;
    if_load  = 1'b0;
    id_load  = 1'b0;
    ex_load  = 1'b0;
    if_clr   = 1'b0;
    id_clr   = 1'b0;
    ex_clr   = 1'b0;
    unique case (state_q)
      StRun: begin
        fetch_en = ~stall | redirect;
        if (hlt) begin
          flush   = 1'b1;
          pc_d    = ex_pc + PC_W'(1);
          if_clr  = 1'b1;
          id_clr  = 1'b1;
          ex_clr  = 1'b1;
          state_d = StHalt;
        end else if (redirect) begin
          flush  = 1'b1;
          pc_d   = jdest;
          if_clr = 1'b1;
          id_clr = 1'b1;
          ex_clr = 1'b1;
        end else if (stall) begin
          ex_clr = 1'b1;
        end else begin
          pc_d    = pc_q + PC_W'(1);
          if_load = 1'b1;
          id_load = 1'b1;
          ex_load = 1'b1;
        end
      end
      StIdle, StHalt: begin
        if_clr = 1'b1;
        id_clr = 1'b1;
        ex_clr = 1'b1;
        if (start) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  // Retired instructions are counted as they leave EX.
  always_comb begin
    retire_cnt_d = retire_cnt_q + CNT_W'(ex_valid);
  end

  // State, pc and retire counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  fetch_seq_stage_shift #(.W(PC_W)) u_if_stage (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .load_i  (if_load),
    .clr_i   (if_clr),
    .pc_i    (pc_q),
    .valid_i (1'b1),
    .pc_o    (if_pc),
    .valid_o (if_valid)
  );

  fetch_seq_stage_shift #(.W(PC_W)) u_id_stage (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .load_i  (id_load),
    .clr_i   (id_clr),
    .pc_i    (if_pc),
    .valid_i (if_valid),
    .pc_o    (id_pc),
    .valid_o (id_valid)
  );

  fetch_seq_stage_shift #(.W(PC_W)) u_ex_stage (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .load_i  (ex_load),
    .clr_i   (ex_clr),
    .pc_i    (id_pc),
    .valid_i (id_valid),
    .pc_o    (ex_pc),
    .valid_o (ex_valid)
  );

  assign imem_addr  = pc_q;
  assign halted     = (state_q == StHalt);
  assign retire_cnt = retire_cnt_q;

endmodule
